// File: rtl/jk_ctrl_pkg.sv
// Shared op codes and FSM state encoding for the JK bank sequencer.
package jk_ctrl_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr, modulo NREQ.
module jk_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] gid
);

  localparam int ID_W = $clog2(NREQ);

  logic found;
  int   p;

  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    p     = 0;
    for (int k = 0; k < NREQ; k++) begin
      p = int'(ptr) + k;
      if (p >= NREQ) p = p - NREQ;
      if (en && !found && valid[p]) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        gid      = ID_W'(p);
      end
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Round-robin sequencer that applies latched JK commands, one bit per step,
// to a bank of NBITS flops; toggles may repeat to form pulse trains.
module jk_bank_sequencer
  import jk_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [IDX_W*NREQ-1:0]    req_idx,
  input  logic [CNT_W*NREQ-1:0]    req_cnt,
  output logic [NBITS-1:0]         q,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     done_err
);

  localparam int ID_W = $clog2(NREQ);

  state_t             state_reg, state_next;
  logic [1:0]         op_reg, op_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   steps_reg, steps_next;
  logic [ID_W-1:0]    owner_reg, owner_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [NBITS-1:0]   q_reg, q_next, hit;
  logic               done_reg, done_next;
  logic [ID_W-1:0]    done_id_reg, done_id_next;
  logic               done_err_reg, done_err_next;

  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    gid;
  logic [1:0]         g_op;
  logic [CNT_W-1:0]   g_cnt;
  logic               exec, idx_oor;

  jk_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid (req_valid),
    .ptr   (ptr_reg),
    .en    (state_reg == ST_IDLE),
    .grant (grant),
    .gid   (gid)
  );

  assign exec    = (state_reg == ST_EXEC);
  assign idx_oor = (32'(idx_reg) >= NBITS);
  assign g_op    = req_op[2*int'(gid) +: 2];
  assign g_cnt   = req_cnt[CNT_W*int'(gid) +: CNT_W];

  // Each cell only sees its J/K when the latched index selects it.
  generate
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_cell
      assign hit[gi]    = exec && (idx_reg == IDX_W'(gi));
      assign q_next[gi] = !hit[gi]          ? q_reg[gi] :
                          (op_reg == OP_HOLD) ? q_reg[gi] :
                          (op_reg == OP_RST)  ? 1'b0 :
                          (op_reg == OP_SET)  ? 1'b1 : ~q_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    idx_next      = idx_reg;
    steps_next    = steps_reg;
    owner_next    = owner_reg;
    ptr_next      = ptr_reg;
    done_next     = 1'b0;
    done_id_next  = done_id_reg;
    done_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|grant) begin
          op_next    = g_op;
          idx_next   = req_idx[IDX_W*int'(gid) +: IDX_W];
          // Only toggles repeat; a zero count still runs once.
          steps_next = (g_op == OP_TGL && g_cnt != '0) ? g_cnt : CNT_W'(1);
          owner_next = gid;
          ptr_next   = (gid == ID_W'(NREQ-1)) ? '0 : gid + ID_W'(1);
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (steps_reg == CNT_W'(1)) begin
          state_next    = ST_IDLE;
          done_next     = 1'b1;
          done_id_next  = owner_reg;
          done_err_next = idx_oor;
        end else begin
          steps_next = steps_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_HOLD;
      idx_reg      <= '0;
      steps_reg    <= '0;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      q_reg        <= '0;
      done_reg     <= 1'b0;
      done_id_reg  <= '0;
      done_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      idx_reg      <= idx_next;
      steps_reg    <= steps_next;
      owner_reg    <= owner_next;
      ptr_reg      <= ptr_next;
      q_reg        <= q_next;
      done_reg     <= done_next;
      done_id_reg  <= done_id_next;
      done_err_reg <= done_err_next;
    end
  end

  assign req_ready = grant;
  assign q         = q_reg;
  assign busy      = exec;
  assign done      = done_reg;
  assign done_id   = done_id_reg;
  assign done_err  = done_err_reg;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Scoreboard bench: grants are predicted and expected completions queued; done pops and compares.
module tb_jk_bank_sequencer;
  import jk_ctrl_pkg::*;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op = '0;
  logic [IDX_W*NREQ-1:0] req_idx = '0;
  logic [CNT_W*NREQ-1:0] req_cnt = '0;
  logic [NBITS-1:0]      q;
  logic                  busy, done, done_err;
  logic [ID_W-1:0]       done_id;

  logic [NREQ-1:0]       v6 = '0;
  logic [NREQ-1:0]       rdy6;
  logic [2*NREQ-1:0]     op6 = '0;
  logic [IDX_W*NREQ-1:0] idx6 = '0;
  logic [CNT_W*NREQ-1:0] cnt6 = '0;
  logic [5:0]            q6;
  logic                  busy6, done6, err6;
  logic [ID_W-1:0]       id6;

  jk_bank_sequencer #(.NREQ(NREQ), .NBITS(NBITS), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_idx(req_idx), .req_cnt(req_cnt), .q(q), .busy(busy), .done(done),
    .done_id(done_id), .done_err(done_err));

  jk_bank_sequencer #(.NREQ(NREQ), .NBITS(6), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_dut6 (
    .clk(clk), .rst(rst), .req_valid(v6), .req_ready(rdy6), .req_op(op6),
    .req_idx(idx6), .req_cnt(cnt6), .q(q6), .busy(busy6), .done(done6),
    .done_id(id6), .done_err(err6));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int              id;
    logic [NBITS-1:0] q;
    logic            err;
    int              cyc;
  } exp_t;

  exp_t            sb[$];
  logic [NBITS-1:0] mq = '0;
  int              mptr = 0;

  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) begin
        g[(p + k) % NREQ] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Monitor: predict each accepted command and compare each completion.
  int              m_r, m_steps, m_idx, m_cnt;
  logic [1:0]      m_op;
  exp_t            m_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        check("grant", 32'(req_ready), 32'(model_grant(req_valid, mptr)));
        m_r = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) m_r = i;
        m_op    = req_op[2*m_r +: 2];
        m_idx   = int'(req_idx[IDX_W*m_r +: IDX_W]);
        m_cnt   = int'(req_cnt[CNT_W*m_r +: CNT_W]);
        m_steps = (m_op == OP_TGL) ? ((m_cnt == 0) ? 1 : m_cnt) : 1;
        if (m_idx < NBITS) begin
          case (m_op)
            OP_RST:  mq[m_idx] = 1'b0;
            OP_SET:  mq[m_idx] = 1'b1;
            OP_TGL:  if (m_steps % 2 == 1) mq[m_idx] = ~mq[m_idx];
            default: ;
          endcase
        end
        m_e.id  = m_r;
        m_e.q   = mq;
        m_e.err = (m_idx >= NBITS);
        m_e.cyc = cyc + m_steps + 1;
        sb.push_back(m_e);
        mptr = (m_r + 1) % NREQ;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          m_e = sb.pop_front();
          check("done_id", 32'(done_id), 32'(m_e.id));
          check("done_q", 32'(q), 32'(m_e.q));
          check("done_err", 32'(done_err), 32'(m_e.err));
          check("done_cycle", 32'(cyc), 32'(m_e.cyc));
        end
      end
    end
  end

  int grant_log[$];
  int gcyc_log[$];

  task automatic set_req(input int r, input logic [1:0] op, input int idx, input int cnt);
    req_op[2*r +: 2]          = op;
    req_idx[IDX_W*r +: IDX_W] = IDX_W'(idx);
    req_cnt[CNT_W*r +: CNT_W] = CNT_W'(cnt);
  endtask

  // Raise the masked valids and drop each one after it is granted.
  task automatic batch(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] g;
    int n;
    grant_log.delete();
    gcyc_log.delete();
    @(posedge clk); #1 req_valid = mask;
    n = 0;
    while (req_valid != '0 && n < 100) begin
      @(negedge clk);
      g = req_ready;
      for (int i = 0; i < NREQ; i++)
        if (g[i]) begin
          grant_log.push_back(i);
          gcyc_log.push_back(cyc);
        end
      @(posedge clk); #1 req_valid = req_valid & ~g;
      n++;
    end
    if (req_valid != '0) begin
      check("grant_timeout", 32'(req_valid), 32'(0));
      req_valid = '0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) return;
    end
    check("idle_timeout", 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("rst_q", 32'(q), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    sb.delete();
    mq   = '0;
    mptr = 0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run6(input int idx, input logic err, input logic [5:0] qexp);
    @(posedge clk); #1 v6 = 4'b0001; op6[1:0] = OP_SET; idx6[IDX_W-1:0] = IDX_W'(idx);
    @(negedge clk); check("d6_ready", 32'(rdy6), 32'(4'b0001));
    @(posedge clk); #1 v6 = '0;
    @(negedge clk); check("d6_busy", 32'(busy6), 32'(1));
    @(negedge clk);
    check("d6_done", 32'(done6), 32'(1));
    check("d6_err", 32'(err6), 32'(err));
    check("d6_q", 32'(q6), 32'(qexp));
  endtask

  initial begin
    // Reset asserted before the first clock edge.
    #2 rst = 1'b1;
    #1;
    check("init_q", 32'(q), 32'(0));
    check("init_busy", 32'(busy), 32'(0));
    check("init_done", 32'(done), 32'(0));
    check("init_ready", 32'(req_ready), 32'(0));
    check("init_err", 32'(done_err), 32'(0));
    check("init_id", 32'(done_id), 32'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Single set.
    set_req(0, OP_SET, 3, 0);
    batch(4'b0001);
    wait_idle();
    check("set_q3", 32'(q[3]), 32'(1));

    // Toggle train of 5 from q[0]=0, watched every cycle.
    set_req(0, OP_TGL, 0, 5);
    batch(4'b0001);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("tgl_busy", 32'(busy), 32'(k < 5));
      check("tgl_q0", 32'(q[0]), 32'(k % 2));
    end
    wait_idle();
    set_req(0, OP_TGL, 0, 0);
    batch(4'b0001);
    wait_idle();
    check("tgl0_q0", 32'(q[0]), 32'(0));

    // Arbitration from a fresh pointer.
    do_reset();
    for (int r = 0; r < NREQ; r++) set_req(r, OP_SET, r, 0);
    batch(4'b1111);
    wait_idle();
    check("arb_n", 32'(grant_log.size()), 32'(4));
    for (int i = 0; i < grant_log.size(); i++) check("arb_order", 32'(grant_log[i]), 32'(i));
    for (int i = 1; i < gcyc_log.size(); i++)
      check("arb_gap", 32'(gcyc_log[i] - gcyc_log[i-1]), 32'(2));
    set_req(0, OP_TGL, 4, 3);
    set_req(2, OP_RST, 1, 7);
    batch(4'b0101);
    wait_idle();
    check("wrap_n", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() == 2) begin
      check("wrap_first", 32'(grant_log[0]), 32'(0));
      check("wrap_second", 32'(grant_log[1]), 32'(2));
    end
    check("wrap_q", 32'(q), 32'(8'h1D));

    // Abort a long toggle in its fourth step.
    set_req(0, OP_TGL, 0, 10);
    batch(4'b0001);
    repeat (2) @(posedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    check("abort_q", 32'(q), 32'(0));
    set_req(0, OP_SET, 2, 0);
    set_req(3, OP_SET, 5, 0);
    batch(4'b1001);
    wait_idle();
    if (grant_log.size() == 2) begin
      check("post_abort_first", 32'(grant_log[0]), 32'(0));
      check("post_abort_second", 32'(grant_log[1]), 32'(3));
    end else begin
      check("post_abort_n", 32'(grant_log.size()), 32'(2));
    end

    // Highest in-range index, then out-of-range on the 6-bit bank.
    set_req(1, OP_SET, 7, 0);
    batch(4'b0010);
    wait_idle();
    check("idx7_q", 32'(q[7]), 32'(1));
    run6(7, 1'b1, 6'b000000);
    run6(5, 1'b0, 6'b100000);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
